apb_arbiter_master: RTL

Round-robin APB master that shares one APB bus between NR internal requesters. Each requester presents a transaction through a valid/ready handshake. The block arbitrates among them and drives a protocol-correct SETUP/ACCESS sequence toward an APB slave. It returns the read data and error status to the granted requester. It sits between internal bus clients (CSR bridges, DMA descriptor fetch) and the APB peripheral fabric.

---
 rtl/apb_arbiter_master_if.sv | 44 ++++
 rtl/apb_arbiter_master.sv | 134 +++++++++++++
 2 files changed

// File: rtl/apb_arbiter_master_if.sv
// Bundle between the requester side, the arbiter and the APB slave.
// The master modport is the arbiter's view.
interface apb_arbiter_master_if #(
  parameter int NR = 2,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [NR-1:0]    i_req_valid;
  logic [NR-1:0]    o_req_ready;
  logic [NR-1:0]    i_req_write;
  logic [NR*AW-1:0] i_req_addr;
  logic [NR*DW-1:0] i_req_wdata;
  logic [NR-1:0]    o_resp_valid;
  logic [DW-1:0]    o_resp_rdata;
  logic             o_resp_err;
  logic             PSEL;
  logic             PENABLE;
  logic             PWRITE;
  logic [AW-1:0]    PADDR;
  logic [DW-1:0]    PWDATA;
  logic             PREADY;
  logic             PSLVERR;
  logic [DW-1:0]    PRDATA;

  modport master (
    input  i_req_valid, i_req_write,
    input  i_req_addr, i_req_wdata,
    input  PREADY, PSLVERR, PRDATA,
    output o_req_ready, o_resp_valid,
    output o_resp_rdata, o_resp_err,
    output PSEL, PENABLE, PWRITE,
    output PADDR, PWDATA
  );

  modport slave (
    output i_req_valid, i_req_write,
    output i_req_addr, i_req_wdata,
    output PREADY, PSLVERR, PRDATA,
    input  o_req_ready, o_resp_valid,
    input  o_resp_rdata, o_resp_err,
    input  PSEL, PENABLE, PWRITE,
    input  PADDR, PWDATA
  );
endinterface

// File: rtl/apb_arbiter_master.sv
// Round-robin APB master sharing one APB bus between NR requesters.
// One outstanding transfer; back-to-back SETUP after a completing ACCESS.
module apb_arbiter_master #(
  parameter int NR = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic                  PCLK,
  input logic                  PRESETn,
  apb_arbiter_master_if.master bus
);

  localparam int IW = $clog2(NR);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   grant_q;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   idx;
  logic            found;
  logic            done;
  logic            accept;
  logic            sel_write;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            write_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [NR-1:0]   resp_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;

  // Round-robin search; lowest offset from pointer+1 wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = NR; i >= 1; i--) begin
      idx = IW'((int'(ptr_q) + i) % NR);
      if (bus.i_req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Payload mux for the winning requester.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NR; k++) begin
      if (pick == IW'(k)) begin
        sel_write = bus.i_req_write[k];
        sel_addr  = bus.i_req_addr[k*AW +: AW];
        sel_wdata = bus.i_req_wdata[k*DW +: DW];
      end
    end
  end

  assign done   = (state_q == ACCESS) && bus.PREADY;
  assign accept = PRESETn && found &&
                  ((state_q == IDLE) || done);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (done) state_d = accept ? SETUP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Latch grant and payload on acceptance.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ptr_q   <= IW'(NR - 1);
      grant_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      ptr_q   <= pick;
      grant_q <= pick;
      write_q <= sel_write;
      addr_q  <= sel_addr;
      wdata_q <= sel_write ? sel_wdata : '0;
    end
  end

  // Capture slave response; strobe the owner next cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      resp_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      resp_q <= '0;
      if (done) begin
        resp_q  <= NR'(1) << grant_q;
        rdata_q <= write_q ? '0 : bus.PRDATA;
        err_q   <= bus.PSLVERR;
      end
    end
  end

  assign bus.o_req_ready  = accept ? (NR'(1) << pick) : '0;
  assign bus.o_resp_valid = resp_q;
  assign bus.o_resp_rdata = rdata_q;
  assign bus.o_resp_err   = err_q;
  assign bus.PSEL         = (state_q != IDLE);
  assign bus.PENABLE      = (state_q == ACCESS);
  assign bus.PWRITE       = write_q;
  assign bus.PADDR        = addr_q;
  assign bus.PWDATA       = wdata_q;

endmodule
